mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide unit with its own control sequencer and HI/LO registers for the single-cycle MIPS core.
- Accepts MULT, MULTU, DIV and DIVU from the main control/decode.
- Runs an iterative shift-add multiplier or a restoring divider for 32 iterations.
- Drives a stall request back to the core whenever a HI/LO read is attempted while an operation is in flight.

---
 rtl/mdu_sequencer.sv | 149 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers.
// Shift-add multiplier and restoring divider, WIDTH iterations each.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count, count_n;
  logic [W2-1:0]    acc, acc_n;
  logic [WIDTH-1:0] dsor, dsor_n;
  logic             is_div, is_div_n;
  logic             qsign, qsign_n;
  logic             rsign, rsign_n;
  logic [WIDTH-1:0] hi_n, lo_n;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   rsh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] rem_nx;
  logic [W2-1:0]    mul_step, div_step;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Signed ops negate negative operands; unsigned ops pass through.
  assign rs_neg = ~op[0] & rs_val[WIDTH-1];
  assign rt_neg = ~op[0] & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // Multiply: add multiplicand to upper half on LSB, then shift right.
  assign madd = {1'b0, acc[W2-1:WIDTH]} + {1'b0, dsor};
  assign mul_step = acc[0] ? {madd, acc[WIDTH-1:1]}
                           : {1'b0, acc[W2-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; restoring step.
  assign rsh    = acc[W2-1:WIDTH-1];
  assign diff   = {1'b0, rsh} - {2'b0, dsor};
  assign rem_nx = diff[WIDTH+1] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign div_step = {rem_nx, acc[WIDTH-2:0], ~diff[WIDTH+1]};

  assign prod    = qsign ? -acc : acc;
  assign quo_fix = qsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix = rsign ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];

  assign busy  = (state != IDLE);
  assign stall = read_req & busy;

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_n  = state;
    count_n  = count;
    acc_n    = acc;
    dsor_n   = dsor;
    is_div_n = is_div;
    qsign_n  = qsign;
    rsign_n  = rsign;
    hi_n     = hi;
    lo_n     = lo;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (op[1] && rt_val == '0) begin
            hi_n = rs_val;
            lo_n = '1;
          end else begin
            state_n  = RUN;
            count_n  = '0;
            acc_n    = {{WIDTH{1'b0}}, op[1] ? rs_mag : rt_mag};
            dsor_n   = op[1] ? rt_mag : rs_mag;
            is_div_n = op[1];
            qsign_n  = rs_neg ^ rt_neg;
            rsign_n  = rs_neg;
          end
        end else begin
          if (mthi) hi_n = wdata;
          if (mtlo) lo_n = wdata;
        end
      end
      RUN: begin
        acc_n   = is_div ? div_step : mul_step;
        count_n = count + 1'b1;
        if (count == CW'(WIDTH - 1)) state_n = FIXUP;
      end
      FIXUP: begin
        if (is_div) begin
          hi_n = rem_fix;
          lo_n = quo_fix;
        end else begin
          hi_n = prod[W2-1:WIDTH];
          lo_n = prod[WIDTH-1:0];
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      dsor   <= '0;
      is_div <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      acc    <= acc_n;
      dsor   <= dsor_n;
      is_div <= is_div_n;
      qsign  <= qsign_n;
      rsign  <= rsign_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer.
// Inputs change on negedge; outputs are checked just after.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        read_req;
  logic [31:0] hi, lo;
  logic        busy, stall;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .wdata    (wdata),
    .read_req (read_req),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch op, count busy cycles, then check cycles and HI/LO.
  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_cycles"}, 32'(n), 32'd33);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = MULT;
    rs_val   = '0;
    rt_val   = '0;
    mthi     = 1'b0;
    mtlo     = 1'b0;
    wdata    = '0;
    read_req = 1'b1;
    @(negedge clk);
    tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    reset    = 1'b0;
    read_req = 1'b0;
    tick();

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd7,
           32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_min", MULT, 32'h80000000, 32'h80000000,
           32'h40000000, 32'h0);
    run_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000);

    // Divide by zero: immediate write, never busy.
    start  = 1'b1;
    op     = DIVU;
    rs_val = 32'd5;
    rt_val = 32'd0;
    tick();
    start = 1'b0;
    chk("dz_busy", 32'(busy), 32'h0);
    chk("dz_hi", hi, 32'd5);
    chk("dz_lo", lo, 32'hFFFFFFFF);
    tick();
    chk("dz_busy2", 32'(busy), 32'h0);

    // mthi in IDLE leaves lo alone.
    mthi  = 1'b1;
    wdata = 32'h1234;
    tick();
    mthi = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 32'hFFFFFFFF);

    // MULT 6 * -2 with stall, stray start and mthi mid-run.
    start  = 1'b1;
    op     = MULT;
    rs_val = 32'd6;
    rt_val = 32'hFFFFFFFE;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      read_req = (c >= 5);
      start    = (c == 10);
      mthi     = (c == 10);
      mtlo     = (c == 10);
      wdata    = 32'hDEAD;
      op       = DIVU;
      rs_val   = 32'd9;
      rt_val   = 32'd0;
      #1;
      chk($sformatf("run_busy_c%0d", c), 32'(busy), 32'h1);
      chk($sformatf("run_stall_c%0d", c), 32'(stall),
          (c >= 5) ? 32'h1 : 32'h0);
      chk($sformatf("run_hold_hi_c%0d", c), hi, 32'h1234);
      chk($sformatf("run_hold_lo_c%0d", c), lo, 32'hFFFFFFFF);
      tick();
    end
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    chk("run_end_busy", 32'(busy), 32'h0);
    chk("run_end_stall", 32'(stall), 32'h0);
    chk("run_end_hi", hi, 32'hFFFFFFFF);
    chk("run_end_lo", lo, 32'hFFFFFFF4);
    read_req = 1'b0;
    tick();
    chk("run_after_busy", 32'(busy), 32'h0);

    // Reset during a DIV abandons it.
    start  = 1'b1;
    op     = DIV;
    rs_val = 32'd100;
    rt_val = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    run_op("multu_small", MULTU, 32'd3, 32'd4, 32'h0, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
